iterative_right_shifter: RTL and testbench

- Multi-cycle right-shift unit for the RISC-V datapath: SRL/SRLI and SRA/SRAI, one bit position per clock.
- Complements the existing combinational 1-bit left shifter used in branch/jump offset generation.
- Sits beside the ALU. Control raises start, stalls while busy, and captures result on done.
- Trades latency for area versus a barrel shifter.

---
 rtl/iterative_right_shifter_if.sv | 31 +++
 rtl/iterative_right_shifter.sv | 90 +++++++++
 tb/tb_iterative_right_shifter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/iterative_right_shifter_if.sv
// Handshake/data bundle for iterative_right_shifter.
//   start  : request, accepted only while the unit is idle
//   a      : operand, sampled with start
//   shamt  : shift amount 0..n-1, sampled with start
//   arith  : 1 = sign fill (SRA), 0 = zero fill (SRL), sampled with start
//   busy   : unit is not idle
//   done   : one-cycle pulse, result valid in that cycle
//   result : shift register contents, final value held until next accept
// master = requester (control/ALU side), slave = the shifter.
interface iterative_right_shifter_if #(
    parameter int n  = 32,
    parameter int SW = 5
) ();
    logic          start;
    logic [n-1:0]  a;
    logic [SW-1:0] shamt;
    logic          arith;
    logic          busy;
    logic          done;
    logic [n-1:0]  result;

    modport master (
        output start, a, shamt, arith,
        input  busy, done, result
    );

    modport slave (
        input  start, a, shamt, arith,
        output busy, done, result
    );
endinterface

// File: rtl/iterative_right_shifter.sv
// Multi-cycle right shifter for SRL/SRLI and SRA/SRAI, one bit per clock.
// Ports:
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-low reset
//   bus : iterative_right_shifter_if slave modport (start/a/shamt/arith in,
//         busy/done/result out)
// A start accepted at edge k produces done in the cycle after edge k+shamt;
// the unit then spends one cycle in IDLE before it can accept again.
module iterative_right_shifter #(
    parameter int n  = 32,
    parameter int SW = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    iterative_right_shifter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q,  state_d;
    logic [n-1:0]  result_q, result_d;
    logic [SW-1:0] count_q,  count_d;
    logic          fill_q,   fill_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        fill_d   = fill_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    result_d = bus.a;
                    count_d  = bus.shamt;
                    // Fill bit is fixed at accept so later edges need no sign logic.
                    fill_d   = bus.arith & bus.a[n-1];
                    state_d  = (bus.shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                result_d = {fill_q, result_q[n-1:1]};
                count_d  = count_q - SW'(1);
                if (count_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            count_q  <= '0;
            fill_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            count_q  <= count_d;
            fill_q   <= fill_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_iterative_right_shifter.sv
module tb_iterative_right_shifter;
    localparam int N   = 32;
    localparam int SWL = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    iterative_right_shifter_if #(.n(N), .SW(SWL)) bus ();

    iterative_right_shifter #(.n(N), .SW(SWL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        int unsigned de;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned free_edge = 0;
    int unsigned acc_edge = 0;
    int unsigned sh_cur = 0;
    logic [31:0] a_cur = '0;
    logic        ar_cur = 1'b0;
    bit          active = 1'b0;
    logic [31:0] held = '0;
    bit          mon_en = 1'b0;

    function automatic logic [31:0] ref_shift(logic [31:0] v, int unsigned k, logic ar);
        if (ar) return 32'($signed(v) >>> k);
        return v >> k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: advances on each edge, decides acceptance from its own timeline.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            sbq.delete();
            active    = 1'b0;
            held      = '0;
            free_edge = cyc + 1;
            mon_en    = 1'b1;
        end else if (bus.start === 1'b1 && cyc >= free_edge) begin
            acc_edge  = cyc;
            sh_cur    = int'(bus.shamt);
            a_cur     = bus.a;
            ar_cur    = bus.arith;
            active    = 1'b1;
            held      = ref_shift(bus.a, sh_cur, bus.arith);
            free_edge = cyc + sh_cur + 2;
            sbq.push_back('{ref_shift(bus.a, sh_cur, bus.arith), cyc + sh_cur});
        end
    end

    // Monitor: samples DUT outputs on the falling edge.
    always @(negedge clk) begin
        bit          inwin;
        logic [31:0] exp_res;
        exp_t        e;
        if (mon_en) begin
            inwin   = active && cyc >= acc_edge && cyc <= acc_edge + sh_cur;
            exp_res = inwin ? ref_shift(a_cur, cyc - acc_edge, ar_cur) : held;
            chk("busy", {31'b0, bus.busy}, {31'b0, inwin});
            chk("done", {31'b0, bus.done}, {31'b0, inwin && cyc == acc_edge + sh_cur});
            chk("result", bus.result, exp_res);
            if (bus.done === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got done with result %h, expected no done (edge %0d)",
                             bus.result, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_result", bus.result, e.res);
                    chk("sb_done_edge", cyc, e.de);
                end
            end
        end
    end

    task automatic wait_free();
        int unsigned n = 0;
        while (cyc + 1 < free_edge) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL wait_idle: got still busy after %0d cycles, expected idle", n);
                return;
            end
        end
    endtask

    task automatic pulse(input logic [31:0] av, input logic [4:0] sh, input logic ar);
        bus.a     = av;
        bus.shamt = sh;
        bus.arith = ar;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic issue(input logic [31:0] av, input logic [4:0] sh, input logic ar);
        wait_free();
        pulse(av, sh, ar);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.shamt = '0;
        bus.arith = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        issue(32'h8000_0000, 5'd4, 1'b0);
        issue(32'h8000_0000, 5'd4, 1'b1);
        issue(32'h7FFF_FFF0, 5'd4, 1'b1);
        issue(32'hDEAD_BEEF, 5'd0, 1'b0);
        issue(32'h8000_0000, 5'd31, 1'b1);
        issue(32'h8000_0000, 5'd31, 1'b0);

        // Requests during SHIFT and DONE are dropped
        issue(32'h0000_00F0, 5'd4, 1'b0);
        repeat (3) @(negedge clk);
        pulse(32'hFFFF_FFFF, 5'd1, 1'b0);
        pulse(32'hFFFF_FFFF, 5'd1, 1'b0);
        issue(32'h1234_5678, 5'd3, 1'b1);

        // Reset in the middle of a shift
        issue(32'hA5A5_A5A5, 5'd10, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        issue(32'h0000_0055, 5'd2, 1'b0);

        // start held high: re-accept every shamt+2 edges
        wait_free();
        bus.a     = 32'h0000_0100;
        bus.shamt = 5'd8;
        bus.arith = 1'b0;
        bus.start = 1'b1;
        repeat (35) @(negedge clk);
        bus.start = 1'b0;

        // Randomized operations with occasional dropped requests
        for (int i = 0; i < 40; i++) begin
            issue($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) pulse($urandom, 5'($urandom_range(0, 31)), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
